accumulator_ram: RTL and testbench

Register-file style accumulator storage for the systolic array datapath: one entry per array column/row (ARRAY_SIZE entries of DATA_WIDTH bits). Partial sums are written synchronously on the clock edge and read back combinationally, so the accumulate logic can read, add and write back within a single cycle. A synchronous active-low reset clears every entry to zero before a new accumulation pass.

---
 rtl/accum_pkg.sv | 10 +
 rtl/accumulator_ram.sv | 55 +++++
 tb/tb_accumulator_ram.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared constants and word type for the accumulator storage
package accum_pkg;

    localparam int ACC_DATA_WIDTH = 32;
    localparam int ACC_ARRAY_SIZE = 16;
    localparam int ACC_ADDR_WIDTH = $clog2(ACC_ARRAY_SIZE);

    typedef logic [ACC_DATA_WIDTH-1:0] acc_word_t;

endpackage

// File: rtl/accumulator_ram.sv
// rtl/accumulator_ram.sv - accumulator register file, sync write / comb read (optional ACCUM_RAM_RDW_BYPASS_EN)
module accumulator_ram
    import accum_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int ARRAY_SIZE = ACC_ARRAY_SIZE,
    parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] dout
);

    // One extra bit so a non-power-of-two depth compares cleanly against the address.
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(ARRAY_SIZE);

    logic [DATA_WIDTH-1:0] mem [ARRAY_SIZE];
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] stored_word;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr] <= din;
        end
    end

    assign stored_word = rd_in_range ? mem[rd_addr] : '0;

`ifdef ACCUM_RAM_RDW_BYPASS_EN
    // Forward the word being written so read-add-write chains see it before the edge.
    always_comb begin
        dout = stored_word;
        if (!rst_n) begin
            dout = '0;
        end else if (wr_en && wr_in_range && (wr_addr == rd_addr)) begin
            dout = din;
        end
    end
`else
    assign dout = stored_word;
`endif

endmodule

// File: tb/tb_accumulator_ram.sv
// tb/tb_accumulator_ram.sv - scoreboard bench for accumulator_ram
module tb_accumulator_ram;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          tb_clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] din;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] dout;

    logic [DW-1:0] exp_q  [$];
    string         name_q [$];
    logic          sample_pulse;
    int            checks;
    int            errors;

    accumulator_ram dut (
        .clk     (tb_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .din     (din),
        .rd_addr (rd_addr),
        .dout    (dout)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    // Monitor: each sample strobe presents one read result to be scored.
    always @(posedge sample_pulse) begin
        logic [DW-1:0] exp_v;
        string         nm;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_sample got=%08h expected=<none>", dout);
        end else begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            if (dout !== exp_v) begin
                errors = errors + 1;
                $display("FAIL %s got=%08h expected=%08h", nm, dout, exp_v);
            end
        end
    end

    task automatic check_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_v, input string nm);
        rd_addr = addr;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        #2;
        sample_pulse = 1'b1;
        #1;
        sample_pulse = 1'b0;
    endtask

    task automatic sweep(input logic [DW-1:0] base, input logic add_index, input string nm);
        for (int i = 0; i < N; i++) begin
            @(negedge tb_clk);
            check_read(AW'(i), add_index ? base + DW'(i) : base,
                       $sformatf("%s_a%0d", nm, i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        sample_pulse = 1'b0;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        din          = '0;
        rd_addr      = '0;

        // Reset for one edge, then everything reads zero.
        @(negedge tb_clk);
        @(negedge tb_clk);
        rst_n = 1'b1;
        sweep(32'h0, 1'b0, "reset_zero");

        // Fill every entry with a distinct pattern.
        for (int i = 0; i < N; i++) begin
            @(negedge tb_clk);
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            din     = 32'hCAFE0000 + DW'(i);
        end
        @(negedge tb_clk);
        wr_en = 1'b0;
        sweep(32'hCAFE0000, 1'b1, "fill");

        // Disabled write must not change anything.
        @(negedge tb_clk);
        wr_addr = 4'd5;
        din     = 32'hDEADBEEF;
        @(negedge tb_clk);
        check_read(4'd5, 32'hCAFE0005, "no_write_en");

        // Back-to-back overwrites of one address.
        @(negedge tb_clk);
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        din     = 32'h11111111;
        @(negedge tb_clk);
        din     = 32'h22222222;
        @(negedge tb_clk);
        wr_en   = 1'b0;
        check_read(4'd3, 32'h22222222, "overwrite_a3");
        check_read(4'd4, 32'hCAFE0004, "neighbour_a4");

        // Read during write to the same address, sampled before and after the edge.
        @(negedge tb_clk);
        wr_en   = 1'b1;
        wr_addr = 4'd9;
        din     = 32'h12345678;
`ifdef ACCUM_RAM_RDW_BYPASS_EN
        check_read(4'd9, 32'h12345678, "rdw_before_edge");
`else
        check_read(4'd9, 32'hCAFE0009, "rdw_before_edge");
`endif
        @(negedge tb_clk);
        wr_en = 1'b0;
        check_read(4'd9, 32'h12345678, "rdw_after_edge");

        // Reset wins over a simultaneous write and clears everything.
        @(negedge tb_clk);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd7;
        din     = 32'hA5A5A5A5;
        @(negedge tb_clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        check_read(4'd7, 32'h0, "reset_beats_write_a7");
        sweep(32'h0, 1'b0, "reset_clear");

        @(negedge tb_clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
